// File: rtl/radix_bist.sv
// radix_bist: signed WIDTHxWIDTH radix-4 (modified Booth) sequential multiplier
// with a built-in self-test wrapper.
//
// User mode multiplies user_x * user_y in LOAD + 4 CALC cycles. Test mode
// (active_test sampled 1 at the accepting start edge) runs BIST_VECTORS LFSR
// operand pairs through the same datapath and compares each product against a
// combinational reference multiply.
//
// Optional build macro RADIX_BIST_MISR_EN:
//   defined   - a 16-bit MISR compacts every BIST product; result = signature.
//   undefined - no MISR logic; result = last BIST product.
//
// Ports:
//   clk          in   clock, rising edge
//   user_reset   in   asynchronous active-low reset
//   active_test  in   1 = next accepted start launches a BIST run
//   user_x       in   multiplicand, signed
//   user_y       in   multiplier, signed
//   user_start   in   start request, rising-edge detected
//   result       out  signed product or BIST result
//   ready        out  result valid, block idle
//   bist_pass    out  last BIST run had no mismatches
//   bist_done    out  a BIST run has completed since reset

module radix_bist #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned BIST_VECTORS = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 user_reset,
    input  logic                 active_test,
    input  logic [WIDTH-1:0]     user_x,
    input  logic [WIDTH-1:0]     user_y,
    input  logic                 user_start,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 bist_pass,
    output logic                 bist_done
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned NSTEP = WIDTH / 2;
    localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int unsigned IW    = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StCheck,
        StDone
    } state_e;

    state_e           r_state;
    logic             r_start_q;
    logic             r_mode;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_vec;
    logic [15:0]      r_lfsr;
    logic             r_fail;

    logic             w_start_edge;
    logic [WIDTH:0]   w_yext;
    logic [IW-1:0]    w_bpos;
    logic [2:0]       w_trip;
    logic [PW-1:0]    w_xext;
    logic [PW-1:0]    w_x2;
    logic [PW-1:0]    w_ysx;
    logic [PW-1:0]    w_pp_sel;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_ref;
    logic             w_mismatch;
    logic             w_last_calc;
    logic             w_last_vec;
    logic [15:0]      w_lfsr_next;
    logic [PW-1:0]    w_bist_result;

    assign w_start_edge = user_start & ~r_start_q;

    // Booth recoding: y[-1] is the appended zero at bit 0 of w_yext.
    assign w_yext = {r_y, 1'b0};
    assign w_bpos = IW'({r_cnt, 1'b0});
    assign w_trip = w_yext[w_bpos +: 3];

    assign w_xext = {{WIDTH{r_x[WIDTH-1]}}, r_x};
    assign w_x2   = {w_xext[PW-2:0], 1'b0};
    assign w_ysx  = {{WIDTH{r_y[WIDTH-1]}}, r_y};

    always_comb begin
        w_pp_sel = '0;
        case (w_trip)
            3'b001, 3'b010: w_pp_sel = w_xext;
            3'b011:         w_pp_sel = w_x2;
            3'b100:         w_pp_sel = -w_x2;
            3'b101, 3'b110: w_pp_sel = -w_xext;
            default:        w_pp_sel = '0;
        endcase
    end

    // Partial product aligned to its radix-4 digit position.
    assign w_pp  = w_pp_sel << w_bpos;
    assign w_sum = r_acc + w_pp;

    // Reference multiply on full-width sign-extended operands.
    assign w_ref      = $signed(w_xext) * $signed(w_ysx);
    assign w_mismatch = (r_acc != w_ref);

    assign w_last_calc = (r_cnt == CW'(NSTEP - 1));
    assign w_last_vec  = (r_vec == 8'(BIST_VECTORS - 1));

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

`ifdef RADIX_BIST_MISR_EN
    logic [15:0] r_misr;
    logic [15:0] w_misr_next;

    assign w_misr_next   = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]}
                           ^ r_acc;
    // The last CHECK loads the result, so take the signature including this product.
    assign w_bist_result = w_misr_next;

    always_ff @(posedge clk or negedge user_reset) begin
        if (!user_reset) begin
            r_misr <= '0;
        end else if ((r_state == StIdle || r_state == StDone) && w_start_edge && active_test) begin
            r_misr <= '0;
        end else if (r_state == StCheck) begin
            r_misr <= w_misr_next;
        end
    end
`else
    assign w_bist_result = r_acc;
`endif

    always_ff @(posedge clk or negedge user_reset) begin
        if (!user_reset) begin
            r_state   <= StIdle;
            r_start_q <= 1'b0;
            r_mode    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_vec     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_fail    <= 1'b0;
            result    <= '0;
            ready     <= 1'b0;
            bist_pass <= 1'b0;
            bist_done <= 1'b0;
        end else begin
            r_start_q <= user_start;
            case (r_state)
                StIdle, StDone: begin
                    if (w_start_edge) begin
                        ready   <= 1'b0;
                        r_mode  <= active_test;
                        r_vec   <= '0;
                        r_state <= StLoad;
                        if (active_test) begin
                            r_lfsr <= LFSR_SEED;
                            r_fail <= 1'b0;
                        end
                    end
                end

                StLoad: begin
                    if (r_mode) begin
                        r_x <= r_lfsr[15:8];
                        r_y <= r_lfsr[7:0];
                    end else begin
                        r_x <= user_x;
                        r_y <= user_y;
                    end
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= StCalc;
                end

                StCalc: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last_calc) begin
                        if (r_mode) begin
                            r_state <= StCheck;
                        end else begin
                            result  <= w_sum;
                            ready   <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end

                StCheck: begin
                    if (w_mismatch) begin
                        r_fail <= 1'b1;
                    end
                    r_lfsr <= w_lfsr_next;
                    if (w_last_vec) begin
                        result    <= w_bist_result;
                        ready     <= 1'b1;
                        bist_done <= 1'b1;
                        bist_pass <= ~(r_fail | w_mismatch);
                        r_state   <= StDone;
                    end else begin
                        r_vec   <= r_vec + 8'd1;
                        r_state <= StLoad;
                    end
                end

                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_radix_bist.sv
// Directed bench for radix_bist: user multiplies, signed corners, start edge
// handling, asynchronous reset, BIST pass and injected-fault BIST runs.

module tb_radix_bist;

    logic        clk;
    logic        user_reset;
    logic        active_test;
    logic [7:0]  user_x;
    logic [7:0]  user_y;
    logic        user_start;
    logic [15:0] result;
    logic        ready;
    logic        bist_pass;
    logic        bist_done;

    int n_checks = 0;
    int n_pass   = 0;

    radix_bist dut (
        .clk         (clk),
        .user_reset  (user_reset),
        .active_test (active_test),
        .user_x      (user_x),
        .user_y      (user_y),
        .user_start  (user_start),
        .result      (result),
        .ready       (ready),
        .bist_pass   (bist_pass),
        .bist_done   (bist_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected BIST result built from the LFSR/MISR definitions and a plain multiply.
    function automatic logic [15:0] bist_expect();
        logic [15:0]        lf;
        logic [15:0]        sig;
        logic [15:0]        p;
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        lf  = 16'hACE1;
        sig = '0;
        p   = '0;
        for (int v = 0; v < 16; v++) begin
            sx  = $signed(lf[15:8]);
            sy  = $signed(lf[7:0]);
            p   = sx * sy;
            sig = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ p;
            lf  = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
`ifdef RADIX_BIST_MISR_EN
        return sig;
`else
        return p;
`endif
    endfunction

    // Start a user multiply, scramble inputs after LOAD, check latency and product.
    task automatic run_mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] exp);
        int lat;
        @(negedge clk);
        active_test = 1'b0;
        user_x      = x;
        user_y      = y;
        user_start  = 1'b1;
        @(posedge clk); #1;
        user_start = 1'b0;
        check_eq({tag, "_rdy_lo"}, 32'(ready), 32'd0);
        @(posedge clk); #1;
        lat    = 1;
        user_x = ~x;
        user_y = ~y;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 5);
        check_eq({tag, "_res"}, 32'(result), 32'(exp));
    endtask

    task automatic run_bist(input string tag, input logic exp_pass, input logic [15:0] exp_res);
        int lat;
        @(negedge clk);
        active_test = 1'b1;
        user_start  = 1'b1;
        @(posedge clk); #1;
        user_start  = 1'b0;
        active_test = 1'b0;
        lat = 0;
        while (!ready && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 96);
        check_eq({tag, "_done"}, 32'(bist_done), 32'd1);
        check_eq({tag, "_pass"}, 32'(bist_pass), 32'(exp_pass));
        if (exp_pass) begin
            check_eq({tag, "_res"}, 32'(result), 32'(exp_res));
        end
    endtask

    initial begin
        int lat;
        int drops;
        user_reset  = 1'b0;
        active_test = 1'b0;
        user_x      = '0;
        user_y      = '0;
        user_start  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_pass", 32'(bist_pass), 32'd0);
        check_eq("rst_done", 32'(bist_done), 32'd0);
        user_reset = 1'b1;

        run_mul("m18x100", 8'd18, 8'd100, 16'h0708);
        run_mul("mneg128sq", 8'h80, 8'h80, 16'h4000);
        run_mul("mneg1x127", 8'hFF, 8'h7F, 16'hFF81);
        run_mul("m0xneg77", 8'h00, 8'hB3, 16'h0000);
        run_mul("m127xneg128", 8'h7F, 8'h80, 16'hC080);
        run_mul("m5xneg3", 8'h05, 8'hFD, 16'hFFF1);

        // Start held high: one multiply only, ready stays up while level persists.
        @(negedge clk);
        user_x     = 8'd7;
        user_y     = 8'd9;
        user_start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("hold_lat", lat, 5);
        check_eq("hold_res", 32'(result), 32'd63);
        drops = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (!ready) drops++;
        end
        user_start = 1'b0;
        @(posedge clk); #1;
        if (!ready) drops++;
        check_eq("hold_no_retrig", drops, 0);

        // Start edge during CALC must be ignored.
        @(negedge clk);
        user_x     = 8'd3;
        user_y     = 8'd4;
        user_start = 1'b1;
        @(posedge clk); #1;
        user_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        user_start = 1'b1;
        lat = 2;
        @(posedge clk); #1;
        lat++;
        user_start = 1'b0;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("calc_start_lat", lat, 5);
        check_eq("calc_start_res", 32'(result), 32'd12);

        check_eq("pre_bist_done", 32'(bist_done), 32'd0);
        run_bist("bist_ok", 1'b1, bist_expect());

        run_mul("post_bist", 8'd11, 8'hF6, 16'hFF92);
        check_eq("post_bist_pass", 32'(bist_pass), 32'd1);
        check_eq("post_bist_done", 32'(bist_done), 32'd1);

        force dut.w_pp = 16'h0001;
        run_bist("bist_fault", 1'b0, 16'h0000);
        release dut.w_pp;

        run_mul("post_fault", 8'd6, 8'd7, 16'd42);
        check_eq("post_fault_pass", 32'(bist_pass), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        user_x     = 8'd20;
        user_y     = 8'd20;
        user_start = 1'b1;
        @(posedge clk); #1;
        user_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        user_reset = 1'b0;
        #1;
        check_eq("arst_result", 32'(result), 32'd0);
        check_eq("arst_ready", 32'(ready), 32'd0);
        check_eq("arst_done", 32'(bist_done), 32'd0);
        @(negedge clk);
        user_reset = 1'b1;

        run_mul("after_rst", 8'd18, 8'd100, 16'h0708);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
